// File: rtl/ucode_sequencer.sv
// Microcode sequencer: copies the ROM image into control-store RAM after reset, then
// generates microaddresses from the sequencing field with a return stack and halt detection.
module ucode_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int N_COND      = 4,
    parameter int HALT_ADDR   = 2**ADDR_W - 2,
    localparam int CW         = (N_COND > 1) ? $clog2(N_COND) : 1,
    localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic [2:0]        seq_op,
    input  logic              jump_src,
    input  logic [ADDR_W-1:0] jump_addr_mc,
    input  logic [ADDR_W-1:0] ir,
    input  logic [CW-1:0]     cond_sel,
    input  logic [N_COND-1:0] cond_in,
    output logic [ADDR_W-1:0] cs_addr,
    output logic              cs_ram_we,
    output logic              cs_ready,
    output logic              halted,
    output logic              stack_err,
    output logic [SPW-1:0]    stack_ptr
);

    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_JCOND = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_HOLD  = 3'd5;

    localparam logic [ADDR_W-1:0] HALT_A  = ADDR_W'(HALT_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [SPW-1:0]    ONE_SP  = SPW'(1);
    localparam logic [SPW-1:0]    SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    state_t state;

    // Sized to the full pointer range so any stack_ptr value indexes it without truncation.
    logic [2**SPW-1:0][ADDR_W-1:0] stack_mem;
    logic [2**CW-1:0]              cond_ext;
    logic [ADDR_W-1:0]             tgt, inc, top, nxt_addr;
    logic                          cond_bit, do_push, do_pop, stk_fault, run_step;

    always_comb begin
        // Zero-extending the flags makes out-of-range selects read as 0.
        cond_ext               = '0;
        cond_ext[N_COND-1:0]   = cond_in;
        cond_bit               = cond_ext[cond_sel];
        tgt                    = jump_src ? jump_addr_mc : ir;
        inc                    = cs_addr + ONE_A;
        top                    = stack_mem[stack_ptr - ONE_SP];
        run_step               = (state == S_RUN) && (cs_addr != HALT_A);

        nxt_addr  = inc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        stk_fault = 1'b0;
        case (seq_op)
            OP_JUMP:  nxt_addr = tgt;
            OP_JCOND: if (cond_bit) nxt_addr = tgt;
            OP_CALL: begin
                if (stack_ptr == SP_FULL) begin
                    stk_fault = 1'b1;
                    nxt_addr  = cs_addr;
                end else begin
                    do_push  = 1'b1;
                    nxt_addr = tgt;
                end
            end
            OP_RET: begin
                if (stack_ptr == '0) begin
                    stk_fault = 1'b1;
                    nxt_addr  = cs_addr;
                end else begin
                    do_pop   = 1'b1;
                    nxt_addr = top;
                end
            end
            OP_HOLD:  nxt_addr = cs_addr;
            default:  nxt_addr = inc;
        endcase
    end

    // Stack contents need no reset; only stack_ptr defines what is valid.
    always_ff @(posedge clk) begin
        if (run_step && do_push)
            stack_mem[stack_ptr] <= inc;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state     <= S_LOAD;
            cs_addr   <= '0;
            cs_ram_we <= 1'b1;
            cs_ready  <= 1'b0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
            stack_ptr <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    cs_addr <= inc;
                    if (&cs_addr) begin
                        state     <= S_RUN;
                        cs_ready  <= 1'b1;
                        cs_ram_we <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!run_step) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        cs_addr <= nxt_addr;
                        if (stk_fault) begin
                            state     <= S_HALT;
                            halted    <= 1'b1;
                            stack_err <= 1'b1;
                        end
                        if (do_push) stack_ptr <= stack_ptr + ONE_SP;
                        if (do_pop)  stack_ptr <= stack_ptr - ONE_SP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios plus randomized op streams checked
// against a queue-based behavioural model of the sequencer.
module tb_ucode_sequencer;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic [2:0] seq_op = '0;
    logic       jump_src = 1'b0;
    logic [7:0] jump_addr_mc = '0;
    logic [7:0] ir = '0;
    logic [1:0] cond_sel = '0;
    logic [3:0] cond_in = '0;
    logic [7:0] cs_addr;
    logic       cs_ram_we, cs_ready, halted, stack_err;
    logic [2:0] stack_ptr;
    logic [14:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    // model: state 0 = loading, 1 = running, 2 = halted
    int m_state, m_addr, m_err;
    int m_stk[$];

    localparam logic [14:0] RESET_VEC = {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};

    ucode_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .N_COND(4)) dut (
        .clk(clk), ._reset(rst_l), .seq_op(seq_op), .jump_src(jump_src),
        .jump_addr_mc(jump_addr_mc), .ir(ir), .cond_sel(cond_sel), .cond_in(cond_in),
        .cs_addr(cs_addr), .cs_ram_we(cs_ram_we), .cs_ready(cs_ready), .halted(halted),
        .stack_err(stack_err), .stack_ptr(stack_ptr)
    );

    always #5 clk = ~clk;

    assign obs = {cs_addr, cs_ram_we, cs_ready, halted, stack_err, stack_ptr};

    function automatic void model_reset();
        m_state = 0; m_addr = 0; m_err = 0;
        m_stk.delete();
    endfunction

    function automatic void model_clk();
        int tgt;
        if (m_state == 0) begin
            if (m_addr == 255) begin m_addr = 0; m_state = 1; end
            else m_addr = m_addr + 1;
        end else if (m_state == 1) begin
            if (m_addr == 254) m_state = 2;
            else begin
                tgt = jump_src ? int'(jump_addr_mc) : int'(ir);
                case (seq_op)
                    3'd1: m_addr = tgt;
                    3'd2: m_addr = cond_in[cond_sel] ? tgt : (m_addr + 1) % 256;
                    3'd3: if (m_stk.size() == 4) begin m_err = 1; m_state = 2; end
                          else begin m_stk.push_back((m_addr + 1) % 256); m_addr = tgt; end
                    3'd4: if (m_stk.size() == 0) begin m_err = 1; m_state = 2; end
                          else m_addr = m_stk.pop_back();
                    3'd5: ;
                    default: m_addr = (m_addr + 1) % 256;
                endcase
            end
        end
    endfunction

    function automatic logic [14:0] model_out();
        logic [7:0] a = m_addr[7:0];
        logic [2:0] sp = 3'(m_stk.size());
        return {a, m_state == 0, m_state != 0, m_state == 2, m_err != 0, sp};
    endfunction

    task automatic cyc(input logic [2:0] op, input logic js, input logic [7:0] jm,
                       input logic [7:0] irv, input logic [1:0] cs, input logic [3:0] ci);
        seq_op = op; jump_src = js; jump_addr_mc = jm; ir = irv; cond_sel = cs; cond_in = ci;
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic cyc_rand();
        cyc(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 8'($urandom),
            2'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    task automatic load_image();
        repeat (256) begin
            cyc_rand();
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL load_step: got %h want %h", obs, model_out());
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", obs, RESET_VEC);
        end
        for (int i = 1; i < 256; i++) begin
            cyc_rand();
            n_tests++;
            if (cs_addr !== 8'(i) || cs_ram_we !== 1'b1 || cs_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL load_addr: got addr=%h we=%b rdy=%b want addr=%h we=1 rdy=0",
                         cs_addr, cs_ram_we, cs_ready, 8'(i));
            end
        end
        cyc_rand();
        n_tests++;
        if (obs !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL load_done: got %h want %h", obs, {8'h00, 5'b01000, 2'b0});
        end
    endtask

    task automatic test_branches();
        cyc(3'd1, 1'b1, 8'hFF, 8'h00, 2'd0, 4'h0);
        cyc(3'd0, 1'b1, 8'h12, 8'h34, 2'd0, 4'h0);
        n_tests++;
        if (cs_addr !== 8'h00) begin
            n_fail++; $display("FAIL next_wrap: got %h want 00", cs_addr);
        end
        cyc(3'd1, 1'b0, 8'h99, 8'h42, 2'd0, 4'h0);
        n_tests++;
        if (cs_addr !== 8'h42) begin
            n_fail++; $display("FAIL jump_ir: got %h want 42", cs_addr);
        end
        cyc(3'd1, 1'b1, 8'h10, 8'h00, 2'd0, 4'h0);
        cyc(3'd2, 1'b1, 8'h80, 8'h00, 2'd2, 4'b1011);
        n_tests++;
        if (cs_addr !== 8'h11) begin
            n_fail++; $display("FAIL jcond_false: got %h want 11", cs_addr);
        end
        cyc(3'd1, 1'b1, 8'h10, 8'h00, 2'd0, 4'h0);
        cyc(3'd2, 1'b1, 8'h80, 8'h00, 2'd2, 4'b0100);
        n_tests++;
        if (cs_addr !== 8'h80) begin
            n_fail++; $display("FAIL jcond_true: got %h want 80", cs_addr);
        end
        cyc(3'd5, 1'b1, 8'h33, 8'h00, 2'd0, 4'h0);
        n_tests++;
        if (cs_addr !== 8'h80 || halted !== 1'b0) begin
            n_fail++; $display("FAIL hold: got %h want 80", cs_addr);
        end
    endtask

    task automatic test_call_ret();
        logic [10:0] got, want;
        logic [7:0] tg [4] = '{8'h30, 8'h40, 8'h00, 8'h00};
        logic [2:0] ops [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
        logic [10:0] exp_v [4] = '{{8'h30, 3'd1}, {8'h40, 3'd2}, {8'h32, 3'd1}, {8'h06, 3'd0}};
        cyc(3'd1, 1'b1, 8'h05, 8'h00, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) cyc(3'd0, 1'b0, 8'h00, 8'h00, 2'd0, 4'h0);
            cyc(ops[i], 1'b1, tg[i], 8'hEE, 2'd0, 4'h0);
            got = {cs_addr, stack_ptr};
            want = exp_v[i];
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL call_ret_%0d: got addr/sp %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) cyc(3'd3, 1'b1, 8'(i * 16), 8'h00, 2'd0, 4'h0);
        cyc(3'd3, 1'b1, 8'h50, 8'h00, 2'd0, 4'h0);
        n_tests++;
        if (obs !== {8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4}) begin
            n_fail++; $display("FAIL overflow: got %h want %h", obs, {8'h40, 4'b0111, 3'd4});
        end
        repeat (3) cyc_rand();
        n_tests++;
        if (obs !== {8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4}) begin
            n_fail++; $display("FAIL overflow_frozen: got %h", obs);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        load_image();
        cyc(3'd4, 1'b1, 8'h77, 8'h00, 2'd0, 4'h0);
        n_tests++;
        if (obs !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL underflow: got %h want %h", obs, {8'h00, 4'b0111, 3'd0});
        end
    endtask

    task automatic test_halt();
        do_reset();
        load_image();
        cyc(3'd1, 1'b1, 8'hFE, 8'h00, 2'd0, 4'h0);
        n_tests++;
        if (cs_addr !== 8'hFE || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_jump: got addr=%h h=%b want FE 0", cs_addr, halted);
        end
        cyc_rand();
        n_tests++;
        if (halted !== 1'b1 || cs_addr !== 8'hFE) begin
            n_fail++; $display("FAIL halt_enter: got addr=%h h=%b want FE 1", cs_addr, halted);
        end
        repeat (10) begin
            cyc_rand();
            n_tests++;
            if (obs !== {8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0}) begin
                n_fail++; $display("FAIL halt_frozen: got %h", obs);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (55) cyc_rand();
        n_tests++;
        if (cs_addr !== 8'h37) begin
            n_fail++; $display("FAIL mid_load_addr: got %h want 37", cs_addr);
        end
        #2 rst_l = 1'b0;
        #1;
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL async_load_reset: got %h want %h", obs, RESET_VEC);
        end
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        repeat (255) cyc_rand();
        n_tests++;
        if (cs_addr !== 8'hFF || cs_ram_we !== 1'b1 || cs_ready !== 1'b0) begin
            n_fail++; $display("FAIL reload_len: got addr=%h we=%b rdy=%b want FF 1 0",
                               cs_addr, cs_ram_we, cs_ready);
        end
        cyc_rand();
        n_tests++;
        if (obs !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL reload_done: got %h", obs);
        end
        cyc(3'd3, 1'b1, 8'h20, 8'h00, 2'd0, 4'h0);
        repeat (3) cyc(3'd0, 1'b0, 8'h00, 8'h00, 2'd0, 4'h0);
        #2 rst_l = 1'b0;
        #1;
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL async_run_reset: got %h want %h", obs, RESET_VEC);
        end
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
        load_image();
    endtask

    task automatic test_random();
        int halt_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc_rand();
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++; $display("FAIL random_%0d: got %h want %h", i, obs, model_out());
            end
            if (m_state == 2) halt_cnt++;
            if (halt_cnt > 4) begin
                halt_cnt = 0;
                do_reset();
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_branches();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_halt();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
